piano_octave: RTL and testbench
===============================

# piano_octave

Parametrised successor of the single-octave keypad piano: maps up to 24 one-hot-style keys onto equal-tempered square-wave tones. Adds a runtime octave shift, lowest-key priority, and a configurable sustain tail after release. Sits between the keypad scanner and the speaker/PWM output pin in the 1 MHz system clock domain.

## Interface
- NUM_KEYS, 12: number of keys, 1..24. Key k is semitone k%12 of octave k/12 above C4.
- OCT_MAX, 3: highest octave shift value. Octave register range is 0..OCT_MAX.
- SUSTAIN_CYC, 2000: clock cycles the tone continues after all keys are released. 0 means stop immediately.
- clk  in  1  system clock, 1 MHz; all logic on rising edge.
- rst_x  in  1  synchronous, active-low reset.
- keypad_in  in  NUM_KEYS  key levels, 1 = pressed; any number may be high.
- oct_up  in  1  level input; a rising edge raises the octave by 1, saturating at OCT_MAX.
- oct_dn  in  1  level input; a rising edge lowers the octave by 1, saturating at 0.
- out  out  1  square-wave tone.
- active  out  1  tone is sounding, including during sustain.
- note_idx  out  5  index of the key currently sounding; holds the last value when silent.
- octave  out  2  current octave shift.

## Operation
- Reset (rst_x = 0 at an edge) clears all registers: out = 0, active = 0, note_idx = 0, octave = 0, key_q = 0, the edge-detect flops, the divider count, and the sustain count.
- Input stage:
  - keypad_in, oct_up and oct_dn are registered once (key_q, up_q, dn_q).
  - Edge detect compares up_q/dn_q with their previous values.
  - If up and down rising edges land in the same cycle, octave is unchanged.
- Key selection: the lowest set index in key_q wins.
- Half-period table (cycles at 1 MHz, rounded), for semitones 0..11: 1911, 1804, 1703, 1607, 1517, 1432, 1351, 1276, 1204, 1136, 1073, 1012.
  - Effective half-period: half = table[k%12] >> (k/12 + octave).
  - Width is 11 bits; the minimum reachable value is 1012 >> 4 = 63, so half never reaches 0.
- Divider:
  - cnt counts 0..half-1. At the edge where cnt == half-1, out toggles and cnt ← 0.
  - Output period is 2·half cycles, 50 % duty.
- Tone change: any change of the selected note or of octave while active does the following at the updating edge:
  - loads note_idx;
  - clears cnt;
  - forces out = 0.
  - The new tone then starts from the low phase.
- Release and sustain:
  - When key_q becomes all-zero while active, the current tone keeps running for SUSTAIN_CYC cycles.
  - When the sustain expires: active ← 0, out ← 0, cnt ← 0.
  - Pressing the same key during sustain cancels the sustain with no phase restart.
  - Pressing a different key cancels the sustain and applies the tone-change rule.
- Silent state (active = 0): out is held at 0, cnt is held at 0, and octave still responds to oct_up/oct_dn.

## Timing
- Key presented before edge 0 is captured in key_q at edge 0.
- Edge 1: active = 1, note_idx updated, cnt = 0.
- First rising toggle of out at edge 1 + half; then out toggles every half cycles.
- Octave: oct_up rising before edge 0 → captured at edge 0 → octave updated at edge 1 → tone restart at edge 2 if active.
- Release: key_q first seen all-zero at edge r → active and out drop at edge r + 1 + SUSTAIN_CYC.
  - With SUSTAIN_CYC = 0 they drop at edge r + 1.
- Reset mid-tone: outputs are at their reset values at the first edge with rst_x = 0, regardless of state.
- Glitch-free: out changes only at clock edges and only on a divider terminal count, a tone change, or a stop.

## Test plan
- Reset then press key 0 (defaults): active rises one cycle after capture; out first goes high 1911 cycles later; measured period 3822 cycles, note_idx = 0.
- Keys 0 and 9 pressed together, then key 0 released: note_idx 0 → 9, cnt restarts, period changes 3822 → 2272 cycles.
- With key 9 held, pulse oct_up once: octave = 1 and period = 1136; pulse oct_up four more times → octave saturates at 3, period 284. Raise oct_up and oct_dn in the same cycle: no change.
- NUM_KEYS = 24, press key 21 at octave 0: period 2·(1136 >> 1) = 1136 cycles, note_idx = 21.
- Release with SUSTAIN_CYC = 2000: tone continues, active drops exactly 2001 edges after the release is captured. Re-press the same key at sustain count 1000: no phase discontinuity, active stays 1.
- Assert rst_x = 0 for one cycle mid-tone and mid-sustain: out = 0, active = 0, octave = 0 at that edge. With SUSTAIN_CYC = 0, release stops the tone one edge after capture.

Source files
------------

// File: rtl/piano_octave.sv
// piano_octave: keypad-to-square-wave tone generator with octave shift,
// lowest-key priority and a sustain tail after release.
// All state is registered on the rising edge of the 1 MHz system clock
// with a synchronous active-low reset.

module piano_octave #(
  parameter int NUM_KEYS    = 12,
  parameter int OCT_MAX     = 3,
  parameter int SUSTAIN_CYC = 2000
) (
  input  logic                clk,
  input  logic                rst_x,
  input  logic [NUM_KEYS-1:0] keypad_in,
  input  logic                oct_up,
  input  logic                oct_dn,
  output logic                out,
  output logic                active,
  output logic [4:0]          note_idx,
  output logic [1:0]          octave
);

  // Sustain counter is wide enough to hold SUSTAIN_CYC; at least one bit.
  localparam int               SUS_W    = (SUSTAIN_CYC < 1) ? 1 : $clog2(SUSTAIN_CYC + 1);
  localparam logic [SUS_W-1:0] SUS_LAST = SUS_W'(SUSTAIN_CYC);
  localparam logic [1:0]       OCT_TOP  = 2'(OCT_MAX);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PLAY = 2'd1,
    ST_SUST = 2'd2
  } state_t;

  // Half-period in 1 MHz cycles for each semitone of the base octave (C4..B4).
  function automatic logic [10:0] semitone_half(input logic [3:0] semi);
    logic [10:0] h;
    case (semi)
      4'd0:    h = 11'd1911;
      4'd1:    h = 11'd1804;
      4'd2:    h = 11'd1703;
      4'd3:    h = 11'd1607;
      4'd4:    h = 11'd1517;
      4'd5:    h = 11'd1432;
      4'd6:    h = 11'd1351;
      4'd7:    h = 11'd1276;
      4'd8:    h = 11'd1204;
      4'd9:    h = 11'd1136;
      4'd10:   h = 11'd1073;
      4'd11:   h = 11'd1012;
      default: h = 11'd1911;
    endcase
    return h;
  endfunction

  // Registers
  logic [NUM_KEYS-1:0] key_r;
  logic                up_r;
  logic                dn_r;
  logic                up_prev_r;
  logic                dn_prev_r;
  logic [1:0]          octave_r;
  logic [1:0]          tone_oct_r;   // octave the current tone was started with
  logic [4:0]          note_r;
  logic [10:0]         cnt_r;
  logic                out_r;
  logic                active_r;
  logic [SUS_W-1:0]    sus_r;
  state_t              state_r;

  // Combinational signals
  logic [4:0]          sel_s;
  logic                key_any_s;
  logic                up_edge_s;
  logic                dn_edge_s;
  logic [1:0]          octave_nxt_s;
  logic                note_hi_s;
  logic [3:0]          semi_s;
  logic [2:0]          shift_s;
  logic [10:0]         half_s;
  logic                term_s;
  logic                tone_chg_s;
  logic                stop_s;
  state_t              state_nxt_s;
  logic [4:0]          note_nxt_s;
  logic [1:0]          tone_oct_nxt_s;
  logic [10:0]         cnt_nxt_s;
  logic                out_nxt_s;
  logic                active_nxt_s;
  logic [SUS_W-1:0]    sus_nxt_s;

  assign key_any_s = |key_r;
  assign up_edge_s = up_r & ~up_prev_r;
  assign dn_edge_s = dn_r & ~dn_prev_r;

  // Lowest pressed key wins: scan from the top so the lowest index is written last.
  always_comb begin
    sel_s = 5'd0;
    for (int k = NUM_KEYS - 1; k >= 0; k--) begin
      if (key_r[k]) begin
        sel_s = 5'(k);
      end else begin
        sel_s = sel_s;
      end
    end
  end

  // Octave step on a single rising edge; simultaneous up/down cancel out.
  always_comb begin
    octave_nxt_s = octave_r;
    if (up_edge_s && !dn_edge_s) begin
      if (octave_r < OCT_TOP) begin
        octave_nxt_s = octave_r + 2'd1;
      end else begin
        octave_nxt_s = octave_r;
      end
    end else if (dn_edge_s && !up_edge_s) begin
      if (octave_r != 2'd0) begin
        octave_nxt_s = octave_r - 2'd1;
      end else begin
        octave_nxt_s = octave_r;
      end
    end else begin
      octave_nxt_s = octave_r;
    end
  end

  // Effective half-period of the sounding note: base entry shifted by key octave plus shift.
  always_comb begin
    note_hi_s = (note_r >= 5'd12);
    if (note_hi_s) begin
      semi_s = 4'(note_r - 5'd12);
    end else begin
      semi_s = note_r[3:0];
    end
    shift_s = {2'b00, note_hi_s} + {1'b0, tone_oct_r};
    half_s  = semitone_half(semi_s) >> shift_s;
    term_s  = (cnt_r == (half_s - 11'd1));
  end

  // Tone restart when a key is held and either the winning key or the octave differs;
  // with no key held the sustain tail keeps the tone it started with.
  always_comb begin
    tone_chg_s = key_any_s && ((sel_s != note_r) || (octave_r != tone_oct_r));
    if (key_any_s) begin
      stop_s = 1'b0;
    end else if (state_r == ST_PLAY) begin
      stop_s = (SUSTAIN_CYC == 0);
    end else if (state_r == ST_SUST) begin
      stop_s = (sus_r == SUS_LAST);
    end else begin
      stop_s = 1'b0;
    end
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!rst_x) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (key_any_s) begin
          state_nxt_s = ST_PLAY;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_PLAY, ST_SUST: begin
        if (key_any_s) begin
          state_nxt_s = ST_PLAY;
        end else if (stop_s) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_SUST;
        end
      end
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // FSM output logic: next values of the tone datapath registers.
  always_comb begin
    note_nxt_s     = note_r;
    tone_oct_nxt_s = tone_oct_r;
    cnt_nxt_s      = cnt_r;
    out_nxt_s      = out_r;
    sus_nxt_s      = sus_r;
    active_nxt_s   = (state_nxt_s != ST_IDLE);
    case (state_r)
      ST_IDLE: begin
        cnt_nxt_s = 11'd0;
        out_nxt_s = 1'b0;
        sus_nxt_s = '0;
        if (key_any_s) begin
          note_nxt_s     = sel_s;
          tone_oct_nxt_s = octave_r;
        end else begin
          note_nxt_s     = note_r;
          tone_oct_nxt_s = tone_oct_r;
        end
      end
      ST_PLAY, ST_SUST: begin
        if (tone_chg_s) begin
          // New tone always starts from the low phase.
          note_nxt_s     = sel_s;
          tone_oct_nxt_s = octave_r;
          cnt_nxt_s      = 11'd0;
          out_nxt_s      = 1'b0;
          sus_nxt_s      = '0;
        end else if (stop_s) begin
          cnt_nxt_s = 11'd0;
          out_nxt_s = 1'b0;
          sus_nxt_s = '0;
        end else begin
          if (term_s) begin
            cnt_nxt_s = 11'd0;
            out_nxt_s = ~out_r;
          end else begin
            cnt_nxt_s = cnt_r + 11'd1;
            out_nxt_s = out_r;
          end
          // The edge that first sees the release counts as sustain cycle 1.
          if (key_any_s) begin
            sus_nxt_s = '0;
          end else if (state_r == ST_PLAY) begin
            sus_nxt_s = SUS_W'(1);
          end else begin
            sus_nxt_s = sus_r + SUS_W'(1);
          end
        end
      end
      default: begin
        cnt_nxt_s = 11'd0;
        out_nxt_s = 1'b0;
        sus_nxt_s = '0;
      end
    endcase
  end

  // Input stage: register keys and octave buttons, remember previous button levels.
  always_ff @(posedge clk) begin
    if (!rst_x) begin
      key_r     <= '0;
      up_r      <= 1'b0;
      dn_r      <= 1'b0;
      up_prev_r <= 1'b0;
      dn_prev_r <= 1'b0;
      octave_r  <= 2'd0;
    end else begin
      key_r     <= keypad_in;
      up_r      <= oct_up;
      dn_r      <= oct_dn;
      up_prev_r <= up_r;
      dn_prev_r <= dn_r;
      octave_r  <= octave_nxt_s;
    end
  end

  // Tone datapath registers: note, divider, output phase, sustain count.
  always_ff @(posedge clk) begin
    if (!rst_x) begin
      note_r     <= 5'd0;
      tone_oct_r <= 2'd0;
      cnt_r      <= 11'd0;
      out_r      <= 1'b0;
      active_r   <= 1'b0;
      sus_r      <= '0;
    end else begin
      note_r     <= note_nxt_s;
      tone_oct_r <= tone_oct_nxt_s;
      cnt_r      <= cnt_nxt_s;
      out_r      <= out_nxt_s;
      active_r   <= active_nxt_s;
      sus_r      <= sus_nxt_s;
    end
  end

  assign out      = out_r;
  assign active   = active_r;
  assign note_idx = note_r;
  assign octave   = octave_r;

endmodule

// File: tb/tb_piano_octave.sv
// Directed testbench for piano_octave: a table of key/octave vectors with
// hand-computed periods, plus sequences for latency, sustain, reset and a
// 24-key / zero-sustain instance.
`timescale 1ns/1ps

module tb_piano_octave;

  logic        clk = 1'b0;
  logic        rst_x;
  logic [11:0] keys_a;
  logic        up_a, dn_a;
  logic        out_a, active_a;
  logic [4:0]  note_a;
  logic [1:0]  oct_a;
  logic [23:0] keys_b;
  logic        up_b, dn_b;
  logic        out_b, active_b;
  logic [4:0]  note_b;
  logic [1:0]  oct_b;

  int n_vec = 0;
  int n_err = 0;

  always #500 clk = ~clk;

  piano_octave dut_a (
    .clk(clk), .rst_x(rst_x), .keypad_in(keys_a), .oct_up(up_a), .oct_dn(dn_a),
    .out(out_a), .active(active_a), .note_idx(note_a), .octave(oct_a)
  );

  piano_octave #(.NUM_KEYS(24), .OCT_MAX(3), .SUSTAIN_CYC(0)) dut_b (
    .clk(clk), .rst_x(rst_x), .keypad_in(keys_b), .oct_up(up_b), .oct_dn(dn_b),
    .out(out_b), .active(active_b), .note_idx(note_b), .octave(oct_b)
  );

  typedef struct {
    logic [11:0] keys;
    int          n_up;
    int          n_dn;
    bit          both;
    int          exp_note;
    int          exp_oct;
    int          exp_period;
  } vec_t;

  vec_t vecs[11];

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic pulse(input bit up, input bit dn);
    @(negedge clk);
    up_a = up;
    dn_a = dn;
    repeat (2) @(negedge clk);
    up_a = 1'b0;
    dn_a = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  // Rising-to-rising distance on the selected output, in cycles; -1 on timeout.
  task automatic measure_period(input bit use_b, output int p);
    int   t0;
    int   found;
    logic prev, cur;
    p = -1;
    t0 = 0;
    found = 0;
    prev = use_b ? out_b : out_a;
    for (int i = 0; i < 20000 && found < 2; i++) begin
      @(negedge clk);
      cur = use_b ? out_b : out_a;
      if (cur && !prev) begin
        if (found == 0) t0 = i;
        else p = i - t0;
        found++;
      end
      prev = cur;
    end
  endtask

  initial begin
    int   p;
    int   n;
    int   early;
    int   tog;
    int   bad;
    int   last;
    logic prev;

    //            keys      up dn both note oct period
    vecs[0]  = '{12'h001, 0, 0, 1'b0, 0,  0, 3822};
    vecs[1]  = '{12'h201, 0, 0, 1'b0, 0,  0, 3822};
    vecs[2]  = '{12'h200, 0, 0, 1'b0, 9,  0, 2272};
    vecs[3]  = '{12'h200, 1, 0, 1'b0, 9,  1, 1136};
    vecs[4]  = '{12'h200, 4, 0, 1'b0, 9,  3, 284};
    vecs[5]  = '{12'h200, 0, 0, 1'b1, 9,  3, 284};
    vecs[6]  = '{12'h200, 0, 1, 1'b0, 9,  2, 568};
    vecs[7]  = '{12'h800, 0, 0, 1'b0, 11, 2, 506};
    vecs[8]  = '{12'h0C0, 0, 0, 1'b0, 6,  2, 674};
    vecs[9]  = '{12'h010, 0, 2, 1'b0, 4,  0, 3034};
    vecs[10] = '{12'h002, 0, 1, 1'b0, 1,  0, 3608};

    rst_x  = 1'b0;
    keys_a = '0;
    up_a   = 1'b0;
    dn_a   = 1'b0;
    keys_b = '0;
    up_b   = 1'b0;
    dn_b   = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_out", out_a, 0);
    check("rst_active", active_a, 0);
    check("rst_note", note_a, 0);
    check("rst_octave", oct_a, 0);
    rst_x = 1'b1;

    // First-toggle latency from a fresh press of key 0.
    @(negedge clk);
    keys_a = 12'h001;
    @(posedge clk); #1;                    // edge 0: key captured
    check("lat_edge0_active", active_a, 0);
    @(posedge clk); #1;                    // edge 1: tone starts
    check("lat_edge1_active", active_a, 1);
    check("lat_edge1_note", note_a, 0);
    check("lat_edge1_out", out_a, 0);
    n = 1;
    for (int k = 0; k < 5000; k++) begin
      @(posedge clk); #1;
      n++;
      if (out_a) break;
    end
    check("lat_first_rise_edge", n, 1912);

    // Table-driven vectors.
    for (int i = 0; i < 11; i++) begin
      @(negedge clk);
      keys_a = vecs[i].keys;
      for (int u = 0; u < vecs[i].n_up; u++) pulse(1'b1, 1'b0);
      for (int d = 0; d < vecs[i].n_dn; d++) pulse(1'b0, 1'b1);
      if (vecs[i].both) pulse(1'b1, 1'b1);
      repeat (8) @(negedge clk);
      check($sformatf("v%0d_active", i), active_a, 1);
      check($sformatf("v%0d_note", i), note_a, vecs[i].exp_note);
      check($sformatf("v%0d_octave", i), oct_a, vecs[i].exp_oct);
      measure_period(1'b0, p);
      check($sformatf("v%0d_period", i), p, vecs[i].exp_period);
    end

    // Release with 2000-cycle sustain (key 1, half 1804).
    @(negedge clk);
    keys_a = 12'h000;
    @(posedge clk); #1;                    // edge r: release captured
    check("sus_edge_r_active", active_a, 1);
    early = 0;
    tog = 0;
    prev = out_a;
    for (int k = 1; k <= 2000; k++) begin
      @(posedge clk); #1;
      if (!active_a) early++;
      if (out_a != prev) tog++;
      prev = out_a;
    end
    check("sus_early_drop", early, 0);
    check("sus_tone_runs", (tog >= 1) ? 1 : 0, 1);
    @(posedge clk); #1;                    // edge r + 2001
    check("sus_end_active", active_a, 0);
    check("sus_end_out", out_a, 0);

    // Re-press the same key halfway through sustain: phase must be continuous.
    @(negedge clk);
    keys_a = 12'h002;
    repeat (30) @(negedge clk);
    bad = 0;
    early = 0;
    tog = 0;
    last = -1;
    prev = out_a;
    for (int k = 0; k < 7000; k++) begin
      @(posedge clk); #1;
      if (k == 2000) keys_a = 12'h000;
      if (k == 3000) keys_a = 12'h002;
      if (!active_a) early++;
      if (out_a != prev) begin
        if (last >= 0 && (k - last) != 1804) bad++;
        last = k;
        tog++;
      end
      prev = out_a;
    end
    check("repress_phase_breaks", bad, 0);
    check("repress_active_drops", early, 0);
    check("repress_toggles", (tog >= 3) ? 1 : 0, 1);

    // Reset mid-tone while out is high and octave is nonzero.
    pulse(1'b1, 1'b0);
    n = 0;
    for (int k = 0; k < 5000; k++) begin
      @(negedge clk);
      if (out_a && oct_a == 2'd1) begin
        n = 1;
        break;
      end
    end
    check("rst_tone_pre_high", n, 1);
    rst_x = 1'b0;
    @(posedge clk); #1;
    check("rst_tone_out", out_a, 0);
    check("rst_tone_active", active_a, 0);
    check("rst_tone_octave", oct_a, 0);
    check("rst_tone_note", note_a, 0);
    @(negedge clk);
    rst_x = 1'b1;

    // Reset mid-sustain.
    repeat (50) @(negedge clk);
    keys_a = 12'h000;
    repeat (500) @(negedge clk);
    check("rst_sus_pre_active", active_a, 1);
    rst_x = 1'b0;
    @(posedge clk); #1;
    check("rst_sus_active", active_a, 0);
    check("rst_sus_out", out_a, 0);
    @(negedge clk);
    rst_x = 1'b1;

    // 24-key instance with no sustain.
    @(negedge clk);
    keys_b = 24'h200000;
    repeat (8) @(negedge clk);
    check("b_k21_active", active_b, 1);
    check("b_k21_note", note_b, 21);
    measure_period(1'b1, p);
    check("b_k21_period", p, 1136);
    @(negedge clk);
    keys_b = 24'h202000;
    repeat (8) @(negedge clk);
    check("b_k13_note", note_b, 13);
    measure_period(1'b1, p);
    check("b_k13_period", p, 1804);
    @(negedge clk);
    keys_b = 24'h000000;
    @(posedge clk); #1;                    // edge r: release captured
    check("b_rel_edge_r_active", active_b, 1);
    @(posedge clk); #1;                    // edge r + 1
    check("b_rel_active", active_b, 0);
    check("b_rel_out", out_b, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
